// File: rtl/cpu_phase_sequencer_pkg.sv
// Shared encodings for the phase sequencer: FSM state codes, default phase indices
// and the sub-cycle counter width helper.
package cpu_phase_sequencer_pkg;

    localparam logic [1:0] SEQ_PAUSE = 2'd0;
    localparam logic [1:0] SEQ_RUN   = 2'd1;
    localparam logic [1:0] SEQ_HALT  = 2'd2;

    localparam int PH_IF  = 0;
    localparam int PH_ID  = 1;
    localparam int PH_EX  = 2;
    localparam int PH_MEM = 3;
    localparam int PH_WB  = 4;

    // A one-cycle phase still needs a 1-bit counter so the compare logic stays uniform.
    function automatic int sub_width(input int cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/cpu_phase_sequencer_edge_detect_rise.sv
// Registered rising-edge detector: one-cycle pulse the cycle after din goes 0->1.
// Latency 1 cycle; no backpressure.
module edge_detect_rise (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rise
);

    logic prev_q, prev_d;
    logic rise_q, rise_d;

    always_comb begin
        prev_d = din;
        rise_d = din & ~prev_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            prev_q <= prev_d;
            rise_q <= rise_d;
        end
    end

    assign rise = rise_q;

endmodule

// File: rtl/cpu_phase_sequencer.sv
// Multi-cycle CPU phase sequencer: one-hot phases, registered phase strobes, stall/step/halt control.
// Strobes appear one cycle after a phase's last cycle, together with the retired/FSM update.
module cpu_phase_sequencer
    import cpu_phase_sequencer_pkg::*;
#(
    parameter int NUM_PHASES   = PH_WB + 1,
    parameter int PHASE_CYCLES = 2,
    parameter int MEM_PHASE    = PH_MEM,
    parameter int RETIRE_W     = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  step_mode,
    input  logic                  step_btn,
    input  logic                  mem_stall,
    input  logic                  halt_req,
    output logic [NUM_PHASES-1:0] phase,
    output logic [NUM_PHASES-1:0] phase_strobe,
    output logic                  pc_en,
    output logic                  reg_we_en,
    output logic                  mem_en,
    output logic [RETIRE_W-1:0]   retired,
    output logic                  halted,
    output logic                  paused
);

    localparam int                    SUB_W     = sub_width(PHASE_CYCLES);
    localparam logic [SUB_W-1:0]      SUB_LAST  = SUB_W'(PHASE_CYCLES - 1);
    localparam logic [NUM_PHASES-1:0] PHASE_RST = NUM_PHASES'(1);

    logic [1:0]            state_q, state_d;
    logic [NUM_PHASES-1:0] phase_q, phase_d;
    logic [NUM_PHASES-1:0] strobe_q, strobe_d;
    logic [SUB_W-1:0]      sub_q, sub_d;
    logic                  one_shot_q, one_shot_d;
    logic [RETIRE_W-1:0]   retired_q, retired_d;

    logic step_rise;
    logic in_run;
    logic at_last;
    logic stalled;
    logic advance;
    logic wb_done;

    edge_detect_rise u_step_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (step_btn),
        .rise  (step_rise)
    );

    always_comb begin
        in_run  = (state_q == SEQ_RUN);
        at_last = (sub_q == SUB_LAST);
        // A stall only bites on the last sub-cycle of the memory phase.
        stalled = mem_stall & phase_q[MEM_PHASE] & at_last;
        advance = in_run & at_last & ~stalled;
        wb_done = advance & phase_q[NUM_PHASES-1];
    end

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        strobe_d   = '0;
        sub_d      = sub_q;
        one_shot_d = one_shot_q;
        retired_d  = retired_q;

        if (in_run && !stalled) begin
            sub_d = at_last ? '0 : sub_q + SUB_W'(1);
        end

        if (advance) begin
            strobe_d = phase_q;
            phase_d  = (phase_q << 1) | (phase_q >> (NUM_PHASES - 1));
        end

        if (wb_done) begin
            retired_d = retired_q + RETIRE_W'(1);
        end

        case (state_q)
            SEQ_PAUSE: begin
                if (!step_mode || step_rise) begin
                    state_d    = SEQ_RUN;
                    one_shot_d = step_rise;
                end
            end
            SEQ_RUN: begin
                // Mode and halt decisions are taken only at the instruction boundary.
                if (wb_done) begin
                    if (halt_req) begin
                        state_d    = SEQ_HALT;
                        one_shot_d = 1'b0;
                    end else if (step_mode || one_shot_q) begin
                        state_d    = SEQ_PAUSE;
                        one_shot_d = 1'b0;
                    end
                end
            end
            SEQ_HALT: begin
                state_d = SEQ_HALT;
            end
            default: begin
                state_d = SEQ_PAUSE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= SEQ_PAUSE;
            phase_q    <= PHASE_RST;
            strobe_q   <= '0;
            sub_q      <= '0;
            one_shot_q <= 1'b0;
            retired_q  <= '0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            strobe_q   <= strobe_d;
            sub_q      <= sub_d;
            one_shot_q <= one_shot_d;
            retired_q  <= retired_d;
        end
    end

    assign phase        = phase_q;
    assign phase_strobe = strobe_q;
    assign pc_en        = strobe_q[NUM_PHASES-1];
    assign reg_we_en    = strobe_q[NUM_PHASES-1];
    assign mem_en       = (state_q == SEQ_RUN) & phase_q[MEM_PHASE];
    assign retired      = retired_q;
    assign halted       = (state_q == SEQ_HALT);
    assign paused       = (state_q == SEQ_PAUSE);

endmodule

// File: tb/tb_cpu_phase_sequencer.sv
// Directed bench for cpu_phase_sequencer: default 5x2 instance plus a 3x1 instance with a 4-bit counter.
module tb_cpu_phase_sequencer;

    logic        clk;
    logic        rst_n, step_mode, step_btn, mem_stall, halt_req;
    logic [4:0]  phase, phase_strobe;
    logic        pc_en, reg_we_en, mem_en, halted, paused;
    logic [31:0] retired;

    logic        rst2_n, step_mode2, step_btn2, mem_stall2, halt_req2;
    logic [2:0]  phase2, strobe2;
    logic        pc_en2, reg_we_en2, mem_en2, halted2, paused2;
    logic [3:0]  retired2;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    cpu_phase_sequencer dut (
        .clk (clk), .rst_n (rst_n), .step_mode (step_mode), .step_btn (step_btn),
        .mem_stall (mem_stall), .halt_req (halt_req), .phase (phase),
        .phase_strobe (phase_strobe), .pc_en (pc_en), .reg_we_en (reg_we_en),
        .mem_en (mem_en), .retired (retired), .halted (halted), .paused (paused)
    );

    cpu_phase_sequencer #(.NUM_PHASES(3), .PHASE_CYCLES(1), .MEM_PHASE(1), .RETIRE_W(4)) dut2 (
        .clk (clk), .rst_n (rst2_n), .step_mode (step_mode2), .step_btn (step_btn2),
        .mem_stall (mem_stall2), .halt_req (halt_req2), .phase (phase2),
        .phase_strobe (strobe2), .pc_en (pc_en2), .reg_we_en (reg_we_en2),
        .mem_en (mem_en2), .retired (retired2), .halted (halted2), .paused (paused2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; step_mode = 1'b1; step_btn = 1'b0; mem_stall = 1'b0; halt_req = 1'b0;
        rst2_n = 1'b0; step_mode2 = 1'b0; step_btn2 = 1'b0; mem_stall2 = 1'b0; halt_req2 = 1'b0;
        tick(); tick();
        checks++;
        if (phase !== 5'b00001 || phase_strobe !== 5'b0 || pc_en !== 1'b0 || reg_we_en !== 1'b0 ||
            mem_en !== 1'b0 || retired !== 32'd0 || halted !== 1'b0 || paused !== 1'b1) begin
            errors++;
            $display("FAIL reset_values: phase=%b strobe=%b pc=%b we=%b mem=%b ret=%0d halt=%b pause=%b, want 00001 0 0 0 0 0 0 1",
                     phase, phase_strobe, pc_en, reg_we_en, mem_en, retired, halted, paused);
        end
        rst_n = 1'b1;
        repeat (3) tick();
        checks++;
        if (paused !== 1'b1 || phase !== 5'b00001 || retired !== 32'd0 || phase_strobe !== 5'b0) begin
            errors++;
            $display("FAIL reset_hold_paused: pause=%b phase=%b ret=%0d strobe=%b, want 1 00001 0 0",
                     paused, phase, retired, phase_strobe);
        end
    endtask

    task automatic test_free_run();
        logic [4:0]  exp_strobe, exp_phase;
        logic [31:0] exp_ret;
        step_mode = 1'b0;
        for (int n = 1; n <= 32; n++) begin
            tick();
            exp_phase  = 5'b00001 << (((n - 1) / 2) % 5);
            exp_strobe = (n >= 3 && ((n - 3) % 2) == 0) ? (5'b00001 << (((n - 3) / 2) % 5)) : 5'b0;
            exp_ret    = 32'((n >= 11) + (n >= 21) + (n >= 31));
            checks++;
            if (phase !== exp_phase || phase_strobe !== exp_strobe || pc_en !== exp_strobe[4] ||
                reg_we_en !== exp_strobe[4] || mem_en !== exp_phase[3] || retired !== exp_ret || paused !== 1'b0) begin
                errors++;
                $display("FAIL free_run cycle %0d: phase=%b strobe=%b pc=%b mem=%b ret=%0d pause=%b, want %b %b %b %b %0d 0",
                         n, phase, phase_strobe, pc_en, mem_en, retired, paused,
                         exp_phase, exp_strobe, exp_strobe[4], exp_phase[3], exp_ret);
            end
        end
    endtask

    task automatic test_mem_stall();
        int k, t0, held, bad_strobe;
        k = 0;
        while (!pc_en && k < 20) begin tick(); k++; end
        t0 = cyc;
        k = 0;
        while (!phase[3] && k < 20) begin tick(); k++; end
        checks++;
        if (!phase[3]) begin
            errors++;
            $display("FAIL stall_reach_mem: phase=%b, want bit3 set", phase);
        end
        held = 1;
        bad_strobe = 0;
        tick();
        if (phase[3]) held++;
        mem_stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (phase[3]) held++;
            if (phase_strobe !== 5'b0 || mem_en !== 1'b1) bad_strobe++;
        end
        mem_stall = 1'b0;
        tick();
        if (phase[3]) held++;
        checks++;
        if (held != 6) begin
            errors++;
            $display("FAIL stall_mem_held: phase[3] held %0d cycles, want 6", held);
        end
        checks++;
        if (bad_strobe != 0) begin
            errors++;
            $display("FAIL stall_no_strobe: %0d stalled cycles with strobe or mem_en wrong, want 0", bad_strobe);
        end
        checks++;
        if (phase_strobe !== 5'b01000) begin
            errors++;
            $display("FAIL stall_mem_strobe: strobe=%b, want 01000", phase_strobe);
        end
        k = 0;
        while (!pc_en && k < 20) begin tick(); k++; end
        checks++;
        if (cyc - t0 != 14) begin
            errors++;
            $display("FAIL stall_instr_len: %0d cycles, want 14", cyc - t0);
        end
    endtask

    task automatic test_single_step();
        int extra;
        rst_n = 1'b0;
        step_mode = 1'b1;
        tick();
        rst_n = 1'b1;
        repeat (5) tick();
        checks++;
        if (paused !== 1'b1 || retired !== 32'd0) begin
            errors++;
            $display("FAIL step_idle: pause=%b ret=%0d, want 1 0", paused, retired);
        end
        for (int s = 1; s <= 2; s++) begin
            step_btn = 1'b1;
            repeat (20) tick();
            step_btn = 1'b0;
            repeat (3) tick();
            checks++;
            if (paused !== 1'b1 || retired !== 32'(s)) begin
                errors++;
                $display("FAIL step_press_%0d: pause=%b ret=%0d, want 1 %0d", s, paused, retired, s);
            end
        end
        extra = 0;
        repeat (10) begin
            tick();
            if (paused !== 1'b1) extra++;
        end
        checks++;
        if (extra != 0 || retired !== 32'd2) begin
            errors++;
            $display("FAIL step_no_extra: %0d non-paused cycles, ret=%0d, want 0 2", extra, retired);
        end
    endtask

    task automatic test_halt();
        int k, noisy;
        halt_req  = 1'b1;
        step_mode = 1'b0;
        k = 0;
        while (!halted && k < 30) begin tick(); k++; end
        checks++;
        if (halted !== 1'b1 || retired !== 32'd3 || pc_en !== 1'b1 || paused !== 1'b0) begin
            errors++;
            $display("FAIL halt_entry: halt=%b ret=%0d pc=%b pause=%b after %0d cycles, want 1 3 1 0",
                     halted, retired, pc_en, paused, k);
        end
        checks++;
        if (k != 11) begin
            errors++;
            $display("FAIL halt_latency: %0d cycles, want 11", k);
        end
        noisy = 0;
        for (int i = 0; i < 100; i++) begin
            step_btn  = ((i / 5) % 2) == 1;
            step_mode = ((i / 25) % 2) == 1;
            tick();
            if (phase_strobe !== 5'b0 || mem_en !== 1'b0 || halted !== 1'b1) noisy++;
        end
        step_btn = 1'b0;
        halt_req = 1'b0;
        checks++;
        if (noisy != 0 || retired !== 32'd3 || paused !== 1'b0) begin
            errors++;
            $display("FAIL halt_terminal: %0d bad cycles, ret=%0d pause=%b, want 0 3 0", noisy, retired, paused);
        end
    endtask

    task automatic test_reset_mid();
        int k;
        rst_n = 1'b0;
        tick();
        step_mode = 1'b0;
        rst_n = 1'b1;
        k = 0;
        while (retired != 32'd1 && k < 30) begin tick(); k++; end
        k = 0;
        while (!phase[2] && k < 20) begin tick(); k++; end
        checks++;
        if (retired !== 32'd1 || phase !== 5'b00100) begin
            errors++;
            $display("FAIL rst_mid_setup: ret=%0d phase=%b, want 1 00100", retired, phase);
        end
        rst_n = 1'b0;
        #2;
        checks++;
        if (phase !== 5'b00001 || phase_strobe !== 5'b0 || pc_en !== 1'b0 || reg_we_en !== 1'b0 ||
            mem_en !== 1'b0 || retired !== 32'd0 || halted !== 1'b0 || paused !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_async: phase=%b strobe=%b pc=%b mem=%b ret=%0d halt=%b pause=%b, want 00001 0 0 0 0 0 1",
                     phase, phase_strobe, pc_en, mem_en, retired, halted, paused);
        end
        step_mode = 1'b1;
        tick();
        rst_n = 1'b1;
        repeat (12) tick();
        checks++;
        if (retired !== 32'd0 || paused !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_after: ret=%0d pause=%b, want 0 1", retired, paused);
        end
    endtask

    task automatic test_short_config();
        logic [2:0] exp_s;
        logic [3:0] exp_r;
        rst2_n = 1'b1;
        for (int n = 1; n <= 49; n++) begin
            tick();
            exp_s = (n >= 2) ? (3'b001 << ((n - 2) % 3)) : 3'b000;
            exp_r = 4'(((n - 1) / 3) % 16);
            checks++;
            if (strobe2 !== exp_s || pc_en2 !== exp_s[2] || retired2 !== exp_r || paused2 !== 1'b0) begin
                errors++;
                $display("FAIL short_cfg cycle %0d: strobe=%b pc=%b ret=%0d pause=%b, want %b %b %0d 0",
                         n, strobe2, pc_en2, retired2, paused2, exp_s, exp_s[2], exp_r);
            end
        end
        checks++;
        if (retired2 !== 4'd0) begin
            errors++;
            $display("FAIL short_cfg_wrap: ret=%0d, want 0", retired2);
        end
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_mem_stall();
        test_single_step();
        test_halt();
        test_reset_mid();
        test_short_config();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
